l2_port_arbiter: RTL and testbench
==================================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter LINE_ADDR_WIDTH, default 25: width of a line address (byte address minus offset bits).
REQ-002 Parameter LINE_WIDTH, default 1024: width of one cache line in bits.
REQ-003 Clocking and reset are fixed: one clock, CLK; reset RST_N is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- CLK  in  1  clock; all flops on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IC_ADDR_VALID  in  1  Icache miss request; one-cycle pulse.
- IC_ADDR  in  LINE_ADDR_WIDTH  Icache line address; valid with the pulse.
- IC_DATA  out  LINE_WIDTH  refill line to Icache.
- IC_DATA_VALID  out  1  one-cycle pulse; IC_DATA is valid.
- DC_RD_VALID  in  1  Dcache refill request pulse.
- DC_RD_ADDR  in  LINE_ADDR_WIDTH  Dcache refill line address.
- DC_DATA  out  LINE_WIDTH  refill line to Dcache.
- DC_DATA_VALID  out  1  one-cycle pulse; DC_DATA is valid.
- DC_WB_VALID  in  1  Dcache dirty-line writeback request pulse.
- DC_WB_ADDR  in  LINE_ADDR_WIDTH  writeback line address.
- DC_WB_DATA  in  LINE_WIDTH  writeback line; valid with the pulse.
- DC_WB_DONE  out  1  one-cycle pulse when L2 acknowledges the write.
- L2_REQ_VALID  out  1  L2 request valid; held until accepted.
- L2_REQ_READY  in  1  L2 accepts the request on the edge where VALID & READY.
- L2_REQ_WR  out  1  1 = write, 0 = read.
- L2_REQ_ADDR  out  LINE_ADDR_WIDTH  request line address.
- L2_WDATA  out  LINE_WIDTH  write data.
- L2_RDATA  in  LINE_WIDTH  read data.
- L2_RDATA_VALID  in  1  read response strobe.
- L2_WR_ACK  in  1  write completion strobe.
- BUSY  out  1  high when any request is pending or in flight.
- PROTO_ERR  out  1  sticky protocol-violation flag.

Function
REQ-005 Each requester (IC, DC read, DC writeback) SHALL have one pending register: a valid bit plus the address, and for writeback also the data; a request pulse captures them on the same edge.
REQ-006 At most one L2 transaction SHALL be outstanding at a time.
REQ-007 The FSM SHALL have four states: IDLE, REQ, WAIT_RD, WAIT_WR.
- IDLE -> REQ when any pending bit is set; the grant is made here.
- REQ -> WAIT_RD or WAIT_WR on the edge with L2_REQ_VALID & L2_REQ_READY.
- WAIT_RD -> IDLE on L2_RDATA_VALID.
- WAIT_WR -> IDLE on L2_WR_ACK.
REQ-008 Grant priority: a pending writeback SHALL win; between the two reads, round-robin with a 1-bit last-read-grant pointer that updates only on a read grant.
REQ-009 On grant, the granted pending bit SHALL clear, and L2_REQ_ADDR, L2_REQ_WR and L2_WDATA SHALL be registered from the granted entry.
REQ-010 In REQ, L2_REQ_VALID SHALL be 1 and L2_REQ_ADDR, L2_REQ_WR and L2_WDATA SHALL be stable until accepted; in all other states L2_REQ_VALID SHALL be 0.
REQ-011 Latency from idle: a pulse sampled at edge k SHALL give L2_REQ_VALID high after edge k+1.
REQ-012 Read response: L2_RDATA_VALID sampled at edge m in WAIT_RD SHALL do the following after edge m:
- register L2_RDATA into the owner's data output and pulse the owner's DATA_VALID for one cycle;
- hold that data output until the next response to the same owner.
REQ-013 L2_WR_ACK sampled at edge m in WAIT_WR SHALL pulse DC_WB_DONE for one cycle after edge m.
REQ-014 A new grant SHALL be possible on edge m+1, giving back-to-back service with one idle cycle between transactions.
REQ-015 A pulse from a requester that already has a pending entry or an in-flight transaction SHALL be ignored and SHALL set PROTO_ERR.
- Exception: a pulse on the same edge that completes that requester's transaction is accepted as new pending.
REQ-016 L2_RDATA_VALID outside WAIT_RD, or L2_WR_ACK outside WAIT_WR, SHALL be ignored and SHALL set PROTO_ERR.
REQ-017 Simultaneous pulses from all three requesters SHALL all be captured; service order is WB, then reads by round-robin.
REQ-018 BUSY SHALL equal (state != IDLE) OR (any pending bit set).

Reset
REQ-019 While RST_N = 0, regardless of CLK:
- state = IDLE; all pending bits = 0;
- last-read-grant pointer = DC, so IC wins the first read tie;
- all outputs = 0, including data buses and PROTO_ERR.
REQ-020 Reset asserted mid-transaction SHALL abandon it; no DATA_VALID or DONE pulse SHALL be produced for it afterwards.

Verification
REQ-021 IC pulse with address 0x0000123, L2_REQ_READY = 1, L2_RDATA_VALID three cycles after acceptance with data pattern 0xA5... -> L2_REQ_VALID high 2 cycles after the pulse with address 0x0000123 and WR = 0; IC_DATA_VALID one-cycle pulse carrying 0xA5...; DC_DATA_VALID stays 0.
REQ-022 IC, DC read and DC writeback pulsed in the same cycle -> L2 request order is WB (WR = 1), then IC, then DC; exactly one DC_WB_DONE, one IC_DATA_VALID and one DC_DATA_VALID.
REQ-023 L2_REQ_READY held low for 5 cycles -> L2_REQ_VALID, address and data stable for all 5 cycles; acceptance on the 6th; no duplicate request.
REQ-024 Second IC pulse while the first is in WAIT_RD -> PROTO_ERR = 1 and stays 1; only one IC_DATA_VALID pulse.
REQ-025 Stray L2_RDATA_VALID in IDLE -> PROTO_ERR = 1, no DATA_VALID pulse.
REQ-026 RST_N low for one cycle during WAIT_RD -> all outputs 0 immediately; a later L2_RDATA_VALID produces no IC_DATA_VALID and BUSY = 0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Arbitrates Icache refills, Dcache refills and Dcache writebacks onto a single
// L2 request channel with one outstanding transaction; writebacks win, reads round-robin.
module l2_port_arbiter #(
    parameter int LINE_ADDR_WIDTH = 25,
    parameter int LINE_WIDTH      = 1024
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IC_ADDR_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] IC_ADDR,
    output logic [LINE_WIDTH-1:0]      IC_DATA,
    output logic                       IC_DATA_VALID,
    input  logic                       DC_RD_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] DC_RD_ADDR,
    output logic [LINE_WIDTH-1:0]      DC_DATA,
    output logic                       DC_DATA_VALID,
    input  logic                       DC_WB_VALID,
    input  logic [LINE_ADDR_WIDTH-1:0] DC_WB_ADDR,
    input  logic [LINE_WIDTH-1:0]      DC_WB_DATA,
    output logic                       DC_WB_DONE,
    output logic                       L2_REQ_VALID,
    input  logic                       L2_REQ_READY,
    output logic                       L2_REQ_WR,
    output logic [LINE_ADDR_WIDTH-1:0] L2_REQ_ADDR,
    output logic [LINE_WIDTH-1:0]      L2_WDATA,
    input  logic [LINE_WIDTH-1:0]      L2_RDATA,
    input  logic                       L2_RDATA_VALID,
    input  logic                       L2_WR_ACK,
    output logic                       BUSY,
    output logic                       PROTO_ERR
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, WAIT_WR} state_e;

    localparam logic [1:0] OWN_IC = 2'd0;
    localparam logic [1:0] OWN_DC = 2'd1;
    localparam logic [1:0] OWN_WB = 2'd2;

    state_e                     state_q, state_d;
    logic [1:0]                 owner_q, owner_d;
    logic                       last_dc_q, last_dc_d;

    logic                       ic_pend_q, ic_pend_d;
    logic [LINE_ADDR_WIDTH-1:0] ic_addr_q, ic_addr_d;
    logic                       dc_pend_q, dc_pend_d;
    logic [LINE_ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
    logic                       wb_pend_q, wb_pend_d;
    logic [LINE_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [LINE_WIDTH-1:0]      wb_data_q, wb_data_d;

    logic                       req_wr_q, req_wr_d;
    logic [LINE_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [LINE_WIDTH-1:0]      wdata_q, wdata_d;

    logic [LINE_WIDTH-1:0]      ic_data_q, ic_data_d;
    logic                       ic_dv_q, ic_dv_d;
    logic [LINE_WIDTH-1:0]      dc_data_q, dc_data_d;
    logic                       dc_dv_q, dc_dv_d;
    logic                       wb_done_q, wb_done_d;
    logic                       proto_q, proto_d;

    logic rd_done, wr_done, stray;
    logic ic_inflight, dc_inflight, wb_inflight;
    logic ic_accept, dc_accept, wb_accept;

    assign rd_done = (state_q == WAIT_RD) && L2_RDATA_VALID;
    assign wr_done = (state_q == WAIT_WR) && L2_WR_ACK;
    assign stray   = (L2_RDATA_VALID && (state_q != WAIT_RD)) ||
                     (L2_WR_ACK && (state_q != WAIT_WR));

    assign ic_inflight = (state_q != IDLE) && (owner_q == OWN_IC);
    assign dc_inflight = (state_q != IDLE) && (owner_q == OWN_DC);
    assign wb_inflight = (state_q != IDLE) && (owner_q == OWN_WB);

    // A pulse landing on the edge that completes its own transaction is a legal new request.
    assign ic_accept = IC_ADDR_VALID && !ic_pend_q && (!ic_inflight || rd_done);
    assign dc_accept = DC_RD_VALID   && !dc_pend_q && (!dc_inflight || rd_done);
    assign wb_accept = DC_WB_VALID   && !wb_pend_q && (!wb_inflight || wr_done);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_dc_d  = last_dc_q;
        ic_pend_d  = ic_pend_q;
        ic_addr_d  = ic_addr_q;
        dc_pend_d  = dc_pend_q;
        dc_addr_d  = dc_addr_q;
        wb_pend_d  = wb_pend_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        wdata_d    = wdata_q;
        ic_data_d  = ic_data_q;
        dc_data_d  = dc_data_q;
        ic_dv_d    = 1'b0;
        dc_dv_d    = 1'b0;
        wb_done_d  = 1'b0;
        proto_d    = proto_q | stray |
                     (IC_ADDR_VALID & ~ic_accept) |
                     (DC_RD_VALID   & ~dc_accept) |
                     (DC_WB_VALID   & ~wb_accept);

        case (state_q)
            IDLE: begin
                if (wb_pend_q) begin
                    state_d    = REQ;
                    owner_d    = OWN_WB;
                    wb_pend_d  = 1'b0;
                    req_wr_d   = 1'b1;
                    req_addr_d = wb_addr_q;
                    wdata_d    = wb_data_q;
                end else if (ic_pend_q && (!dc_pend_q || last_dc_q)) begin
                    state_d    = REQ;
                    owner_d    = OWN_IC;
                    ic_pend_d  = 1'b0;
                    req_wr_d   = 1'b0;
                    req_addr_d = ic_addr_q;
                    last_dc_d  = 1'b0;
                end else if (dc_pend_q) begin
                    state_d    = REQ;
                    owner_d    = OWN_DC;
                    dc_pend_d  = 1'b0;
                    req_wr_d   = 1'b0;
                    req_addr_d = dc_addr_q;
                    last_dc_d  = 1'b1;
                end
            end
            REQ: begin
                if (L2_REQ_READY) begin
                    state_d = req_wr_q ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (L2_RDATA_VALID) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IC) begin
                        ic_data_d = L2_RDATA;
                        ic_dv_d   = 1'b1;
                    end else begin
                        dc_data_d = L2_RDATA;
                        dc_dv_d   = 1'b1;
                    end
                end
            end
            WAIT_WR: begin
                if (L2_WR_ACK) begin
                    state_d   = IDLE;
                    wb_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture after grant handling: an accepted pulse never targets an entry cleared this edge.
        if (ic_accept) begin
            ic_pend_d = 1'b1;
            ic_addr_d = IC_ADDR;
        end
        if (dc_accept) begin
            dc_pend_d = 1'b1;
            dc_addr_d = DC_RD_ADDR;
        end
        if (wb_accept) begin
            wb_pend_d = 1'b1;
            wb_addr_d = DC_WB_ADDR;
            wb_data_d = DC_WB_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IC;
            last_dc_q  <= 1'b1;
            ic_pend_q  <= 1'b0;
            ic_addr_q  <= '0;
            dc_pend_q  <= 1'b0;
            dc_addr_q  <= '0;
            wb_pend_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            req_wr_q   <= 1'b0;
            req_addr_q <= '0;
            wdata_q    <= '0;
            ic_data_q  <= '0;
            ic_dv_q    <= 1'b0;
            dc_data_q  <= '0;
            dc_dv_q    <= 1'b0;
            wb_done_q  <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_dc_q  <= last_dc_d;
            ic_pend_q  <= ic_pend_d;
            ic_addr_q  <= ic_addr_d;
            dc_pend_q  <= dc_pend_d;
            dc_addr_q  <= dc_addr_d;
            wb_pend_q  <= wb_pend_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            req_wr_q   <= req_wr_d;
            req_addr_q <= req_addr_d;
            wdata_q    <= wdata_d;
            ic_data_q  <= ic_data_d;
            ic_dv_q    <= ic_dv_d;
            dc_data_q  <= dc_data_d;
            dc_dv_q    <= dc_dv_d;
            wb_done_q  <= wb_done_d;
            proto_q    <= proto_d;
        end
    end

    assign IC_DATA       = ic_data_q;
    assign IC_DATA_VALID = ic_dv_q;
    assign DC_DATA       = dc_data_q;
    assign DC_DATA_VALID = dc_dv_q;
    assign DC_WB_DONE    = wb_done_q;
    assign L2_REQ_VALID  = (state_q == REQ);
    assign L2_REQ_WR     = req_wr_q;
    assign L2_REQ_ADDR   = req_addr_q;
    assign L2_WDATA      = wdata_q;
    assign BUSY          = (state_q != IDLE) || ic_pend_q || dc_pend_q || wb_pend_q;
    assign PROTO_ERR     = proto_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized and directed bench for l2_port_arbiter against a transaction-level
// reference model (requester slots, current owner, accepted flag).
module tb_l2_port_arbiter;

    localparam int AW = 25;
    localparam int LW = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ic_v = 1'b0, dr_v = 1'b0, wb_v = 1'b0;
    logic [AW-1:0] ic_a = '0, dr_a = '0, wb_a = '0;
    logic [LW-1:0] wb_d = '0, l2_rdata = '0;
    logic          l2_ready = 1'b0, l2_rvalid = 1'b0, l2_wack = 1'b0;
    logic [LW-1:0] ic_data, dc_data, l2_wdata;
    logic          ic_dv, dc_dv, wb_done, l2_valid, l2_wr, busy, proto;
    logic [AW-1:0] l2_addr;

    always #5 clk = ~clk;

    l2_port_arbiter #(.LINE_ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .IC_ADDR_VALID(ic_v), .IC_ADDR(ic_a), .IC_DATA(ic_data), .IC_DATA_VALID(ic_dv),
        .DC_RD_VALID(dr_v), .DC_RD_ADDR(dr_a), .DC_DATA(dc_data), .DC_DATA_VALID(dc_dv),
        .DC_WB_VALID(wb_v), .DC_WB_ADDR(wb_a), .DC_WB_DATA(wb_d), .DC_WB_DONE(wb_done),
        .L2_REQ_VALID(l2_valid), .L2_REQ_READY(l2_ready), .L2_REQ_WR(l2_wr),
        .L2_REQ_ADDR(l2_addr), .L2_WDATA(l2_wdata), .L2_RDATA(l2_rdata),
        .L2_RDATA_VALID(l2_rvalid), .L2_WR_ACK(l2_wack), .BUSY(busy), .PROTO_ERR(proto)
    );

    // Reference model: slot 0 = writeback, 1 = Icache read, 2 = Dcache read.
    bit            m_pend[3];
    logic [AW-1:0] m_addr[3];
    logic [LW-1:0] m_wbd;
    int            m_owner;      // -1 when nothing is granted
    bit            m_acc;        // granted request already taken by L2
    bit            m_last_dc;
    logic [LW-1:0] m_ic_data, m_dc_data, m_wdata;
    logic [AW-1:0] m_raddr;
    bit            m_ic_dv, m_dc_dv, m_done, m_wr, m_proto;

    int  sl_delay;
    int  ready_pct = 60;
    bit  stray_en = 1'b0;
    int  vectors = 0;
    int  errors = 0;
    int  n_ic_dv = 0, n_dc_dv = 0, n_done = 0;
    logic [AW:0] acc_log[$];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        for (int k = 0; k < LW / 256; k++)
            check_val($sformatf("%s[%0d]", tag, k), got[k*256 +: 256], exp[k*256 +: 256]);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 3; r++) begin
            m_pend[r] = 1'b0;
            m_addr[r] = '0;
        end
        m_wbd = '0; m_owner = -1; m_acc = 1'b0; m_last_dc = 1'b1;
        m_ic_data = '0; m_dc_data = '0; m_wdata = '0; m_raddr = '0;
        m_ic_dv = 1'b0; m_dc_dv = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_proto = 1'b0;
        sl_delay = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit rd_done, wr_done, fr;
        bit p_old[3];
        int own_old, g;
        for (int r = 0; r < 3; r++) p_old[r] = m_pend[r];
        own_old = m_owner;
        rd_done = (m_owner == 1 || m_owner == 2) && m_acc && l2_rvalid;
        wr_done = (m_owner == 0) && m_acc && l2_wack;
        m_ic_dv = 1'b0; m_dc_dv = 1'b0; m_done = 1'b0;
        if (l2_rvalid && !((m_owner == 1 || m_owner == 2) && m_acc)) m_proto = 1'b1;
        if (l2_wack && !(m_owner == 0 && m_acc)) m_proto = 1'b1;

        if (m_owner < 0) begin
            if (m_pend[0]) g = 0;
            else if (m_pend[1] && m_pend[2]) g = m_last_dc ? 1 : 2;
            else if (m_pend[1]) g = 1;
            else if (m_pend[2]) g = 2;
            else g = -1;
            if (g >= 0) begin
                m_owner = g; m_acc = 1'b0; m_pend[g] = 1'b0;
                m_raddr = m_addr[g]; m_wr = (g == 0);
                if (g == 0) m_wdata = m_wbd;
                else m_last_dc = (g == 2);
            end
        end else if (!m_acc) begin
            if (l2_ready) begin
                m_acc = 1'b1;
                sl_delay = $urandom_range(0, 4);
                $display("txn t=%0t %s addr=%h", $time, m_wr ? "WR" : (m_owner == 1 ? "IC" : "DC"), m_raddr);
            end
        end else if (rd_done) begin
            if (m_owner == 1) begin m_ic_data = l2_rdata; m_ic_dv = 1'b1; end
            else begin m_dc_data = l2_rdata; m_dc_dv = 1'b1; end
            m_owner = -1;
        end else if (wr_done) begin
            m_done = 1'b1;
            m_owner = -1;
        end

        fr = !p_old[0] && (own_old != 0 || wr_done);
        if (wb_v) begin
            if (fr) begin m_pend[0] = 1'b1; m_addr[0] = wb_a; m_wbd = wb_d; end
            else m_proto = 1'b1;
        end
        fr = !p_old[1] && (own_old != 1 || rd_done);
        if (ic_v) begin
            if (fr) begin m_pend[1] = 1'b1; m_addr[1] = ic_a; end
            else m_proto = 1'b1;
        end
        fr = !p_old[2] && (own_old != 2 || rd_done);
        if (dr_v) begin
            if (fr) begin m_pend[2] = 1'b1; m_addr[2] = dr_a; end
            else m_proto = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_val("ic_dv", ic_dv, m_ic_dv);
        check_val("dc_dv", dc_dv, m_dc_dv);
        check_val("wb_done", wb_done, m_done);
        check_val("req_valid", l2_valid, (m_owner >= 0) && !m_acc);
        check_val("busy", busy, (m_owner >= 0) || m_pend[0] || m_pend[1] || m_pend[2]);
        check_val("proto", proto, m_proto);
        check_val("req_addr", l2_addr, m_raddr);
        check_val("req_wr", l2_wr, m_wr);
        check_bus("ic_data", ic_data, m_ic_data);
        check_bus("dc_data", dc_data, m_dc_data);
        check_bus("wdata", l2_wdata, m_wdata);
        if (ic_dv) n_ic_dv++;
        if (dc_dv) n_dc_dv++;
        if (wb_done) n_done++;
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic clock_and_check();
        if (l2_valid && l2_ready) acc_log.push_back({l2_wr, l2_addr});
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        ic_v = 1'b0; dr_v = 1'b0; wb_v = 1'b0;
        l2_rvalid = 1'b0; l2_wack = 1'b0;
    endtask

    task automatic slave_drive();
        l2_ready = 1'b0; l2_rvalid = 1'b0; l2_wack = 1'b0;
        l2_rdata = rand_line();
        if (m_owner >= 0 && !m_acc) l2_ready = ($urandom_range(0, 99) < ready_pct);
        else if (m_owner >= 0) begin
            if (sl_delay == 0) begin
                if (m_owner == 0) l2_wack = 1'b1;
                else l2_rvalid = 1'b1;
            end else sl_delay--;
        end else l2_ready = $urandom_range(0, 1);
        if (stray_en && $urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 1) l2_rvalid = 1'b1;
            else l2_wack = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_v = 1'b0; dr_v = 1'b0; wb_v = 1'b0;
        l2_ready = 1'b0; l2_rvalid = 1'b0; l2_wack = 1'b0;
        m_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles, input bit legal_only);
        bit c0, c1, c2;
        for (int i = 0; i < cycles; i++) begin
            slave_drive();
            c0 = (m_owner == 0) && m_acc && l2_wack;
            c1 = (m_owner == 1) && m_acc && l2_rvalid;
            c2 = (m_owner == 2) && m_acc && l2_rvalid;
            if ($urandom_range(0, 2) == 0 && (!legal_only || (!m_pend[0] && (m_owner != 0 || c0)))) begin
                wb_v = 1'b1; wb_a = AW'($urandom); wb_d = rand_line();
            end
            if ($urandom_range(0, 2) == 0 && (!legal_only || (!m_pend[1] && (m_owner != 1 || c1)))) begin
                ic_v = 1'b1; ic_a = AW'($urandom);
            end
            if ($urandom_range(0, 2) == 0 && (!legal_only || (!m_pend[2] && (m_owner != 2 || c2)))) begin
                dr_v = 1'b1; dr_a = AW'($urandom);
            end
            clock_and_check();
        end
    endtask

    initial begin
        logic [LW-1:0] pat, d23;
        logic [AW-1:0] a23;
        int base;

        #1;
        do_reset();

        // Legal random traffic: the error flag must never rise.
        random_phase(1200, 1'b1);
        check_val("legal_proto_clear", proto, 1'b0);

        // Single Icache refill with a fixed three-cycle read latency.
        do_reset();
        pat = {128{8'hA5}};
        l2_ready = 1'b1; ic_v = 1'b1; ic_a = 25'h0000123;
        clock_and_check();
        check_val("r21_valid_k1", l2_valid, 1'b0);
        clock_and_check();
        check_val("r21_valid_k2", l2_valid, 1'b1);
        check_val("r21_addr", l2_addr, 25'h0000123);
        check_val("r21_wr", l2_wr, 1'b0);
        clock_and_check();
        l2_ready = 1'b0;
        clock_and_check();
        clock_and_check();
        l2_rvalid = 1'b1; l2_rdata = pat;
        clock_and_check();
        check_val("r21_ic_dv", ic_dv, 1'b1);
        check_bus("r21_ic_data", ic_data, pat);
        check_val("r21_dc_dv", dc_dv, 1'b0);
        clock_and_check();
        check_val("r21_ic_dv_end", ic_dv, 1'b0);
        check_bus("r21_ic_hold", ic_data, pat);

        // Reset during WAIT_RD abandons the read.
        l2_ready = 1'b1; ic_v = 1'b1; ic_a = AW'($urandom);
        clock_and_check();
        clock_and_check();
        clock_and_check();
        l2_ready = 1'b0;
        clock_and_check();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_outputs();
        check_val("r26_busy", busy, 1'b0);
        check_bus("r26_ic_data", ic_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        l2_rvalid = 1'b1; l2_rdata = rand_line();
        clock_and_check();
        check_val("r26_no_dv", ic_dv, 1'b0);
        check_val("r26_busy_after", busy, 1'b0);

        // All three requesters pulse together.
        do_reset();
        acc_log.delete();
        base = n_ic_dv; n_ic_dv = 0; n_dc_dv = 0; n_done = 0;
        ready_pct = 100;
        slave_drive();
        wb_v = 1'b1; wb_a = 25'h0000111; wb_d = rand_line();
        ic_v = 1'b1; ic_a = 25'h0000222;
        dr_v = 1'b1; dr_a = 25'h0000333;
        clock_and_check();
        for (int i = 0; i < 40; i++) begin
            slave_drive();
            clock_and_check();
        end
        check_val("r22_n_acc", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check_val("r22_first", acc_log[0], {1'b1, 25'h0000111});
            check_val("r22_second", acc_log[1], {1'b0, 25'h0000222});
            check_val("r22_third", acc_log[2], {1'b0, 25'h0000333});
        end
        check_val("r22_n_done", n_done, 1);
        check_val("r22_n_ic", n_ic_dv, 1);
        check_val("r22_n_dc", n_dc_dv, 1);
        check_val("r22_idle", busy, 1'b0);
        ready_pct = 60;

        // L2 stalls acceptance for five cycles.
        do_reset();
        acc_log.delete();
        a23 = AW'($urandom); d23 = rand_line();
        wb_v = 1'b1; wb_a = a23; wb_d = d23;
        clock_and_check();
        clock_and_check();
        for (int i = 0; i < 5; i++) begin
            check_val("r23_valid", l2_valid, 1'b1);
            check_val("r23_addr", l2_addr, a23);
            check_val("r23_wr", l2_wr, 1'b1);
            check_bus("r23_wdata", l2_wdata, d23);
            clock_and_check();
        end
        l2_ready = 1'b1;
        clock_and_check();
        l2_ready = 1'b0;
        check_val("r23_taken", l2_valid, 1'b0);
        clock_and_check();
        l2_wack = 1'b1;
        clock_and_check();
        check_val("r23_done", wb_done, 1'b1);
        clock_and_check();
        check_val("r23_single", acc_log.size(), 1);

        // Second Icache pulse while the first is outstanding.
        do_reset();
        n_ic_dv = 0;
        l2_ready = 1'b1; ic_v = 1'b1; ic_a = AW'($urandom);
        clock_and_check();
        clock_and_check();
        clock_and_check();
        l2_ready = 1'b0; ic_v = 1'b1; ic_a = AW'($urandom);
        clock_and_check();
        check_val("r24_proto", proto, 1'b1);
        clock_and_check();
        l2_rvalid = 1'b1; l2_rdata = rand_line();
        clock_and_check();
        for (int i = 0; i < 6; i++) clock_and_check();
        check_val("r24_n_ic", n_ic_dv, 1);
        check_val("r24_sticky", proto, 1'b1);
        check_val("r24_idle", busy, 1'b0);

        // Stray read strobe while idle.
        do_reset();
        l2_rvalid = 1'b1; l2_rdata = rand_line();
        clock_and_check();
        check_val("r25_proto", proto, 1'b1);
        check_val("r25_ic_dv", ic_dv, 1'b0);
        check_val("r25_dc_dv", dc_dv, 1'b0);

        // Unconstrained traffic with protocol violations and a mid-run reset.
        do_reset();
        stray_en = 1'b1;
        random_phase(600, 1'b0);
        do_reset();
        random_phase(600, 1'b0);
        n_ic_dv = base;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
